// File: rtl/ff_bank_arbiter_pkg.sv
// Shared opcodes and sequencer states for the round-robin register-bank arbiter.
package ff_bank_pkg;

    localparam logic [1:0] OP_LOAD     = 2'b00;
    localparam logic [1:0] OP_CLEAR    = 2'b01;
    localparam logic [1:0] OP_PRESET   = 2'b10;
    localparam logic [1:0] OP_CONFLICT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_APPLY,
        ST_ACK
    } state_t;

endpackage

// File: rtl/ff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last', wrapping.
module rr_pick #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic [$clog2(NREQ)-1:0] winner,
    output logic                    valid
);

    localparam int unsigned IDXW = $clog2(NREQ);

    logic [IDXW-1:0] w_idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_idx  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = IDXW'((32'(last) + k) % NREQ);
            if (!valid && req[w_idx]) begin
                valid  = 1'b1;
                winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/ff_bank_arbiter.sv
// Round-robin arbiter/sequencer applying one load/clear/preset per grant to a shared bank.
module ff_bank_arbiter
    import ff_bank_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [NREQ-1:0]       req,
    input  logic [2*NREQ-1:0]     op,
    input  logic [WIDTH*NREQ-1:0] d,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      q,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned IDXW = $clog2(NREQ);

    state_t            r_state;
    logic [IDXW-1:0]   r_last;
    logic [IDXW-1:0]   r_win;
    logic [1:0]        r_op;
    logic [WIDTH-1:0]  r_d;

    logic [IDXW-1:0]   w_winner;
    logic              w_valid;
    logic [NREQ-1:0]   w_onehot;
    logic [1:0]        w_op;
    logic [WIDTH-1:0]  w_d;

    rr_pick #(
        .NREQ(NREQ)
    ) u_pick (
        .req    (req),
        .last   (r_last),
        .winner (w_winner),
        .valid  (w_valid)
    );

    assign w_onehot = NREQ'(1) << w_winner;
    assign w_op     = op[2*w_winner +: 2];
    assign w_d      = d[WIDTH*w_winner +: WIDTH];

    // Opcode and data are captured at grant so later input changes cannot leak into the bank.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
            r_last  <= IDXW'(NREQ - 1);
            r_win   <= '0;
            r_op    <= OP_LOAD;
            r_d     <= '0;
            q       <= '0;
            gnt     <= '0;
            ack     <= '0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    ack <= '0;
                    if (w_valid) begin
                        gnt     <= w_onehot;
                        r_win   <= w_winner;
                        r_last  <= w_winner;
                        r_op    <= w_op;
                        r_d     <= w_d;
                        busy    <= 1'b1;
                        r_state <= ST_APPLY;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    case (r_op)
                        OP_LOAD:     q   <= r_d;
                        OP_CLEAR:    q   <= '0;
                        OP_PRESET:   q   <= '1;
                        OP_CONFLICT: err <= 1'b1;
                    endcase
                    ack     <= NREQ'(1) << r_win;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    ack     <= '0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
